// File: rtl/vpu_pkg.sv
// Shared VPU types: responder FSM states, port select, and default bus widths.
package vpu_pkg;

  localparam int VPU_DATA_W = 32;
  localparam int VPU_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } vpu_mem_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } vpu_port_t;

endpackage

// File: rtl/vpu_mem_array.sv
// Flop-based word store: one synchronous write port, one combinational read port.
module vpu_mem_array
  import vpu_pkg::*;
#(
  parameter int DATA_W = VPU_DATA_W,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/vpu_mem_responder.sv
// VPU memory responder: prioritised accept of one request per idle cycle,
// fixed-latency reads, single-cycle writes, sticky error flag.
module vpu_mem_responder
  import vpu_pkg::*;
#(
  parameter int DATA_W = VPU_DATA_W,
  parameter int ADDR_W = VPU_ADDR_W,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_a_req,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic              rd_b_req,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr_c,
  input  logic [DATA_W-1:0] data_c,
  output logic              mem_rdy,
  output logic              mem_valid,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(RD_LAT + 1);
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  vpu_mem_state_t    r_state, w_state_nxt;
  vpu_port_t         r_port, w_load_port;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_cap, r_data_a, r_data_b;
  logic              r_err;

  logic              w_idle, w_acc_wr, w_acc_a, w_acc_b, w_acc_rd;
  logic              w_rd_inr, w_wr_inr, w_drop, w_err_set, w_load;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_arr_rdata, w_rd_word, w_load_data;

  assign w_idle   = (r_state == IDLE);
  assign w_acc_wr = w_idle & wr_req;
  assign w_acc_a  = w_idle & ~wr_req & rd_a_req;
  assign w_acc_b  = w_idle & ~wr_req & ~rd_a_req & rd_b_req;
  assign w_acc_rd = w_acc_a | w_acc_b;

  assign w_rd_addr = w_acc_a ? addr_a : addr_b;
  assign w_rd_inr  = ({1'b0, w_rd_addr} < LP_DEPTH);
  assign w_wr_inr  = ({1'b0, addr_c} < LP_DEPTH);
  assign w_rd_word = w_rd_inr ? w_arr_rdata : '0;

  assign w_drop    = w_idle & ((wr_req & (rd_a_req | rd_b_req)) | (rd_a_req & rd_b_req));
  assign w_err_set = w_drop | (w_acc_wr & ~w_wr_inr) | (w_acc_rd & ~w_rd_inr);

  vpu_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_acc_wr & w_wr_inr),
    .i_waddr (addr_c[IDX_W-1:0]),
    .i_wdata (data_c),
    .i_raddr (w_rd_addr[IDX_W-1:0]),
    .o_rdata (w_arr_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_load_data = r_cap;
    w_load_port = r_port;
    case (r_state)
      IDLE: begin
        if (w_acc_rd) begin
          if (RD_LAT == 1) begin
            // Single-cycle latency bypasses the capture register.
            w_state_nxt = RESP;
            w_load      = 1'b1;
            w_load_data = w_rd_word;
            w_load_port = w_acc_a ? PORT_A : PORT_B;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_W'(RD_LAT - 1);
          end
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = RESP;
          w_load      = 1'b1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_data_a <= '0;
      r_data_b <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_err_set) r_err <= 1'b1;
      if (w_load && (w_load_port == PORT_A)) r_data_a <= w_load_data;
      if (w_load && (w_load_port == PORT_B)) r_data_b <= w_load_data;
    end
  end

  // Read data is sampled at acceptance; it needs no reset.
  always_ff @(posedge clk) begin
    if (w_acc_rd) begin
      r_cap  <= w_rd_word;
      r_port <= w_acc_a ? PORT_A : PORT_B;
    end
  end

  assign mem_rdy   = w_idle;
  assign mem_valid = (r_state == RESP);
  assign data_a    = r_data_a;
  assign data_b    = r_data_b;
  assign err       = r_err;

endmodule

// File: tb/tb_vpu_mem_responder.sv
// Bench for vpu_mem_responder: two instances (RD_LAT=2 and RD_LAT=1) checked per cycle against a transaction-level model.
module tb_vpu_mem_responder;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEP   = 32;
  localparam int BOUND = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ra[2], rb[2], wr[2];
  logic [AW-1:0] aa[2], ab[2], ac[2];
  logic [DW-1:0] dc[2];
  logic          rdy[2], vld[2], er[2];
  logic [DW-1:0] da[2], db[2];

  vpu_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .rd_a_req(ra[0]), .addr_a(aa[0]), .rd_b_req(rb[0]), .addr_b(ab[0]),
    .wr_req(wr[0]), .addr_c(ac[0]), .data_c(dc[0]),
    .mem_rdy(rdy[0]), .mem_valid(vld[0]), .data_a(da[0]), .data_b(db[0]), .err(er[0])
  );

  vpu_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .rd_a_req(ra[1]), .addr_a(aa[1]), .rd_b_req(rb[1]), .addr_b(ab[1]),
    .wr_req(wr[1]), .addr_c(ac[1]), .data_c(dc[1]),
    .mem_rdy(rdy[1]), .mem_valid(vld[1]), .data_a(da[1]), .data_b(db[1]), .err(er[1])
  );

  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Transaction-level model: a read accepted at cycle t is busy for t+1..t+L, valid at t+L.
  int            lat[2] = '{2, 1};
  logic [DW-1:0] m_mem[2][DEP];
  int            cyc[2];
  bit            m_b[2];
  logic [DW-1:0] m_cap[2];
  logic [DW-1:0] e_a[2], e_b[2];
  bit            e_err[2], e_vld[2], e_rdy[2];
  bit            chk_en = 1'b0;

  always @(posedge clk) begin
    int            n;
    logic [AW-1:0] ad;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int k = 0; k < DEP; k++) m_mem[d][k] = '0;
        cyc[d] = 0; e_a[d] = '0; e_b[d] = '0; e_err[d] = 1'b0;
      end else if (cyc[d] == 0) begin
        n = int'(wr[d]) + int'(ra[d]) + int'(rb[d]);
        if (n > 1) e_err[d] = 1'b1;
        if (wr[d]) begin
          if (int'(ac[d]) < DEP) m_mem[d][int'(ac[d])] = dc[d];
          else e_err[d] = 1'b1;
        end else if (ra[d] || rb[d]) begin
          ad = ra[d] ? aa[d] : ab[d];
          m_b[d] = !ra[d];
          if (int'(ad) < DEP) m_cap[d] = m_mem[d][int'(ad)];
          else begin m_cap[d] = '0; e_err[d] = 1'b1; end
          cyc[d] = 1;
        end
      end else if (cyc[d] == lat[d]) begin
        cyc[d] = 0;
      end else begin
        cyc[d]++;
      end
      e_vld[d] = (cyc[d] != 0) && (cyc[d] == lat[d]);
      if (e_vld[d]) begin
        if (m_b[d]) e_b[d] = m_cap[d];
        else        e_a[d] = m_cap[d];
      end
      e_rdy[d] = (cyc[d] == 0);
    end
    if (rst) chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("u%0d.mem_rdy", d),   rdy[d], e_rdy[d]);
        chk($sformatf("u%0d.mem_valid", d), vld[d], e_vld[d]);
        chk($sformatf("u%0d.data_a", d),    da[d],  e_a[d]);
        chk($sformatf("u%0d.data_b", d),    db[d],  e_b[d]);
        chk($sformatf("u%0d.err", d),       er[d],  e_err[d]);
      end
    end
  end

  task automatic clr_all();
    for (int d = 0; d < 2; d++) begin
      ra[d] = 0; rb[d] = 0; wr[d] = 0;
      aa[d] = '0; ab[d] = '0; ac[d] = '0; dc[d] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write1(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v);
    wr[d] = 1'b1; ac[d] = a; dc[d] = v;
    @(negedge clk);
    wr[d] = 1'b0;
  endtask

  // Issue a read and return at the cycle it responds (DUT0 idle assumed).
  task automatic read0(input bit b, input logic [AW-1:0] a);
    if (b) begin rb[0] = 1'b1; ab[0] = a; end
    else   begin ra[0] = 1'b1; aa[0] = a; end
    @(negedge clk);
    ra[0] = 1'b0; rb[0] = 1'b0;
    @(negedge clk);
  endtask

  // Hold a read request until the DUT accepts it; returns in the cycle after acceptance.
  task automatic hold_read(input int d, input bit b, input logic [AW-1:0] a);
    int t;
    t = 0;
    if (b) begin rb[d] = 1'b1; ab[d] = a; end
    else   begin ra[d] = 1'b1; aa[d] = a; end
    while (!rdy[d] && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    chk("hold_accept_in_bound", 32'(t < BOUND), 32'd1);
    @(negedge clk);
    ra[d] = 1'b0; rb[d] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_all();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_rdy", rdy[0], 1'b1);
    chk("reset_err", er[0], 1'b0);
    chk("reset_data_a", da[0], 32'h0);

    // Reset then read A@3: valid in cycle 2, data 0, data_b untouched.
    read0(1'b0, 16'd3);
    chk("rd3_valid", vld[0], 1'b1);
    chk("rd3_data_a", da[0], 32'h0);
    chk("rd3_err", er[0], 1'b0);
    @(negedge clk);
    chk("rd3_rdy_back", rdy[0], 1'b1);

    // Write then read B.
    write1(0, 16'd5, 32'hDEADBEEF);
    rb[0] = 1'b1; ab[0] = 16'd5;
    @(negedge clk);
    rb[0] = 1'b0;
    chk("raw_rdy_c2", rdy[0], 1'b0);
    @(negedge clk);
    chk("raw_valid_c3", vld[0], 1'b1);
    chk("raw_data_b", db[0], 32'hDEADBEEF);
    chk("raw_rdy_c3", rdy[0], 1'b0);
    @(negedge clk);
    chk("raw_rdy_c4", rdy[0], 1'b1);

    // Simultaneous write + read A: write wins, read dropped, err set.
    wr[0] = 1'b1; ac[0] = 16'd1; dc[0] = 32'h11;
    ra[0] = 1'b1; aa[0] = 16'd2;
    @(negedge clk);
    clr_all();
    chk("simul_err", er[0], 1'b1);
    chk("simul_no_valid", vld[0], 1'b0);
    repeat (3) @(negedge clk);
    read0(1'b0, 16'd1);
    chk("simul_write_committed", da[0], 32'h11);
    @(negedge clk);

    // Out of range read and write.
    do_reset();
    write1(0, 16'd6, 32'hCAFE0006);
    read0(1'b1, 16'd6);
    chk("oor_pre_data_b", db[0], 32'hCAFE0006);
    @(negedge clk);
    read0(1'b1, 16'd32);
    chk("oor_valid", vld[0], 1'b1);
    chk("oor_data_b", db[0], 32'h0);
    chk("oor_err", er[0], 1'b1);
    @(negedge clk);
    write1(0, 16'd40, 32'h55);
    read0(1'b0, 16'd8);
    chk("oor_write_discarded", da[0], 32'h0);
    @(negedge clk);

    // Reset mid-read.
    do_reset();
    write1(0, 16'd2, 32'h22);
    ra[0] = 1'b1; aa[0] = 16'd2;
    @(negedge clk);
    ra[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_rdy", rdy[0], 1'b1);
    chk("midrst_valid", vld[0], 1'b0);
    chk("midrst_data_a", da[0], 32'h0);
    repeat (3) @(negedge clk);
    read0(1'b0, 16'd2);
    chk("midrst_mem_cleared", da[0], 32'h0);
    @(negedge clk);

    // Minimum latency with held requests on the RD_LAT=1 instance.
    do_reset();
    write1(1, 16'd0, 32'd7);
    write1(1, 16'd1, 32'd9);
    for (int r = 0; r < 2; r++) begin
      hold_read(1, 1'b0, 16'd0);
      chk("lat1_valid_a", vld[1], 1'b1);
      chk("lat1_data_a", da[1], 32'd7);
      hold_read(1, 1'b1, 16'd1);
      chk("lat1_valid_b", vld[1], 1'b1);
      chk("lat1_data_b", db[1], 32'd9);
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vpu_mem_responder.md
# vpu_mem_responder

Memory-side responder for the VPU operand/result channel. It serves the three-address VPU interface: read port A, read port B (operands and constants), and write port C (results). Storage is a flop-based word array with a fixed, parameterised read latency. The block sits between the VPU top and the local vector scratchpad and owns the `mem_rdy`/`mem_valid` handshake.

## Interface
- `DATA_W`, 32: word width.
- `ADDR_W`, 16: address width on all ports.
- `DEPTH`, 32: number of words; valid addresses are 0..DEPTH-1.
- `RD_LAT`, 2: read latency in cycles; legal range 1..8.

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rd_a_req` in 1: read request on port A.
- `addr_a` in ADDR_W: port A read address.
- `rd_b_req` in 1: read request on port B (operand B or constant).
- `addr_b` in ADDR_W: port B read address.
- `wr_req` in 1: write request on port C.
- `addr_c` in ADDR_W: port C write address.
- `data_c` in DATA_W: write data.
- `mem_rdy` out 1: responder can accept a request this cycle.
- `mem_valid` out 1: one-cycle pulse; read data is valid on `data_a` or `data_b`.
- `data_a` out DATA_W: port A read data.
- `data_b` out DATA_W: port B read data.
- `err` out 1: sticky error flag.

## Operation
- **Accept rule:** a request is accepted in a cycle where `mem_rdy` is high and the request bit is high.
  - Exactly one request is accepted per cycle.
  - Priority is `wr_req` > `rd_a_req` > `rd_b_req`.
  - Lower-priority requests asserted in the same cycle are dropped and set `err`.
- **States:** IDLE, WAIT, RESP. `mem_rdy` is high only in IDLE.
  - IDLE, read accepted: latch the port select. Capture `mem[addr]`, or 0 if the address is out of range. If `RD_LAT`==1, go to RESP. Otherwise go to WAIT with `cnt` = `RD_LAT`-1.
  - WAIT: decrement `cnt`; go to RESP when `cnt`==1.
  - RESP: assert `mem_valid`. Drive captured data onto `data_a` or `data_b` according to the latched port. Return to IDLE.
  - IDLE, write accepted: if `addr_c` < `DEPTH`, `mem[addr_c]` <= `data_c` at the end of the cycle. Stay in IDLE. `mem_rdy` remains high and no `mem_valid` is generated.
- **Out-of-range address** (addr >= `DEPTH`):
  - Read returns 0, still completes with `mem_valid`, and sets `err`.
  - Write is discarded and sets `err`.
- **Output hold:** `data_a` and `data_b` each hold their last response value until the next response on the same port. The other port is unchanged.
- **Requests while busy:** requests asserted while `mem_rdy` is low are ignored. The requester must hold the request until it is accepted. This is not an error.
- **Reset:**
  - All storage words, `data_a`, `data_b`, `err` and `cnt` go to 0.
  - State goes to IDLE. `mem_valid` goes to 0. `mem_rdy` is 1 in the first cycle after reset.
  - Reset mid-read aborts the read; no `mem_valid` is issued.
- **Width rules:**
  - Address compare uses the full `ADDR_W`.
  - Storage is indexed by the low $clog2(`DEPTH`) bits only after the range check passes.
  - `cnt` width is $clog2(`RD_LAT`+1).

## Timing
- Read accepted in cycle 0 → `mem_valid` high in cycle `RD_LAT` only → `mem_rdy` high again in cycle `RD_LAT`+1.
- Read throughput: one read per `RD_LAT`+1 cycles.
- Write accepted in cycle 0 → new data is visible to a read accepted in cycle 1 (read-after-write, no hazard).
- Read data is sampled at acceptance. A write cannot occur during WAIT because `mem_rdy` is low, so no ordering conflicts arise.
- `mem_valid`, `data_a`, `data_b`, `mem_rdy` and `err` are all registered or state-decoded. There are no combinational paths from request inputs to outputs, except `mem_rdy`, which is decoded from state only.

## Structure
- Shared package `vpu_pkg`:
  - State enum `vpu_mem_state_t` {IDLE, WAIT, RESP}.
  - Port-select enum {PORT_A, PORT_B}.
  - Default `DATA_W`/`ADDR_W`, shared with the VPU top.
- Sub-module `vpu_mem_array`: `DEPTH`×`DATA_W` flops, one synchronous write port, one combinational read port, synchronous clear on `rst`.
- The top holds the FSM, latency counter, priority/accept logic, output registers and `err`.

## Test plan
- **Reset then read:** reset, then read A at address 3 → `mem_valid` in cycle 2 (`RD_LAT`=2), `data_a`=0, `data_b` unchanged, `err`=0.
- **Write then read:** write 0xDEADBEEF to address 5 in cycle 0, read B at address 5 in cycle 1 → `data_b`=0xDEADBEEF with `mem_valid` in cycle 3. `mem_rdy` is low in cycles 2–3 and high in cycle 4.
- **Simultaneous requests:** `wr_req` (address 1, 0x11) and `rd_a_req` in the same cycle → write committed, read dropped, `err`=1, no `mem_valid`.
- **Out of range:** read B at address 32 with `DEPTH`=32 → `data_b`=0, `mem_valid` pulses, `err`=1. Write to address 40 → memory unchanged.
- **Reset mid-read:** read accepted in cycle 0, `rst` in cycle 1 → no `mem_valid` ever; all outputs 0; `mem_rdy`=1 in cycle 2.
- **Minimum latency and held requests:** with `RD_LAT`=1, run back-to-back A/B reads of addresses 0/1 preloaded with 7/9, holding requests while `mem_rdy` is low → `mem_valid` one cycle after each accept, `data_a`=7 and `data_b`=9, and no duplicate acceptance.
